// File: rtl/taxi_debounce_event.sv
// Multi-channel switch debouncer: 2-flop sync, prescaled N-sample history, edge pulses.
// Optional long-press detector enabled by defining TAXI_DEBOUNCE_LONG_PRESS_EN.
module taxi_debounce_event #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N        = 4,
  parameter int unsigned RATE     = 125000,
  parameter int unsigned LONG_CNT = 256,
  parameter logic        INIT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] long_press,
  output logic             tick
);

  localparam int unsigned PW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(RATE - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [N-1:0]     hist_q [WIDTH];
  logic [N-1:0]     hist_d [WIDTH];

  // Tick is registered, so it is high in the cycle after the prescaler wraps.
  always_comb begin
    pre_d  = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
    tick_d = (pre_q == PRE_MAX);
    for (int i = 0; i < int'(WIDTH); i++) begin
      hist_d[i] = tick_q ? {hist_q[i][N-2:0], sync2_q[i]} : hist_q[i];
      if (&hist_q[i]) begin
        out_d[i] = 1'b1;
      end else if (~|hist_q[i]) begin
        out_d[i] = 1'b0;
      end else begin
        out_d[i] = out_q[i];
      end
    end
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {WIDTH{INIT}};
      sync2_q <= {WIDTH{INIT}};
      out_q   <= {WIDTH{INIT}};
      rise_q  <= '0;
      fall_q  <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        hist_q[i] <= {N{INIT}};
      end
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign tick = tick_q;

`ifdef TAXI_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CNT + 1);
  localparam logic [LW-1:0] LMAX = LW'(LONG_CNT);

  logic [LW-1:0]    lcnt_q [WIDTH];
  logic [LW-1:0]    lcnt_d [WIDTH];
  logic [WIDTH-1:0] lp_q, lp_d;

  // Counter reads zero in the rise cycle, then counts ticks while held high.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      lcnt_d[i] = lcnt_q[i];
      if (!out_d[i] || rise_d[i]) begin
        lcnt_d[i] = '0;
      end else if (tick_q && (lcnt_q[i] != LMAX)) begin
        lcnt_d[i] = lcnt_q[i] + LW'(1);
      end
      lp_d[i] = (lcnt_d[i] == LMAX) && (lcnt_q[i] != LMAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        lcnt_q[i] <= '0;
      end
    end else begin
      lp_q <= lp_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        lcnt_q[i] <= lcnt_d[i];
      end
    end
  end

  assign long_press = lp_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_taxi_debounce_event.sv
// Bench for taxi_debounce_event: two instances (RATE=1 and RATE=4) against a run-length model.
module tb_taxi_debounce_event;

  localparam int unsigned TB_N = 4;
  localparam int TB_L = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_a, in_b;
  logic [3:0] out_a, rise_a, fall_a, lp_a;
  logic [3:0] out_b, rise_b, fall_b, lp_b;
  logic       tick_a, tick_b;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  taxi_debounce_event #(.WIDTH(4), .N(TB_N), .RATE(1), .LONG_CNT(8), .INIT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a), .rise(rise_a),
    .fall(fall_a), .long_press(lp_a), .tick(tick_a));

  taxi_debounce_event #(.WIDTH(4), .N(TB_N), .RATE(4), .LONG_CNT(8), .INIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b), .rise(rise_b),
    .fall(fall_b), .long_press(lp_b), .tick(tick_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel's level follows the value of its last N consecutive equal
  // samples; one sample per tick, taken from the input two clocks earlier.
  logic [3:0] m_s1 [2], m_s2 [2], m_out [2], m_rise [2], m_fall [2], m_lp [2];
  logic       m_tick [2];
  int         m_e [2];
  int         m_run [2][4];
  logic       m_rval [2][4];
  int         m_lcnt [2][4];
  logic       mo_old, mo_new;
  int         ml_old, mrate;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = '0; m_s2[k] = '0; m_out[k] = '0; m_rise[k] = '0;
        m_fall[k] = '0; m_lp[k] = '0; m_tick[k] = 1'b0; m_e[k] = 0;
        for (int c = 0; c < 4; c++) begin
          m_run[k][c] = int'(TB_N); m_rval[k][c] = 1'b0; m_lcnt[k][c] = 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mrate = (k == 0) ? 1 : 4;
        for (int c = 0; c < 4; c++) begin
          mo_old = m_out[k][c];
          mo_new = (m_run[k][c] >= int'(TB_N)) ? m_rval[k][c] : mo_old;
          m_out[k][c]  = mo_new;
          m_rise[k][c] = mo_new & ~mo_old;
          m_fall[k][c] = ~mo_new & mo_old;
          ml_old = m_lcnt[k][c];
          if (!mo_new || m_rise[k][c]) m_lcnt[k][c] = 0;
          else if (m_tick[k] && m_lcnt[k][c] < TB_L) m_lcnt[k][c]++;
`ifdef TAXI_DEBOUNCE_LONG_PRESS_EN
          m_lp[k][c] = (m_lcnt[k][c] == TB_L) && (ml_old != TB_L);
`else
          m_lp[k][c] = 1'b0;
`endif
          if (m_tick[k]) begin
            if (m_s2[k][c] == m_rval[k][c]) begin
              if (m_run[k][c] < 1000) m_run[k][c]++;
            end else begin
              m_rval[k][c] = m_s2[k][c];
              m_run[k][c] = 1;
            end
          end
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = (k == 0) ? in_a : in_b;
        m_e[k]++;
        m_tick[k] = (m_e[k] % mrate) == 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_a", {47'd0, out_a, rise_a, fall_a, lp_a, tick_a},
          {47'd0, m_out[0], m_rise[0], m_fall[0], m_lp[0], m_tick[0]});
      chk("cmp_b", {47'd0, out_b, rise_b, fall_b, lp_b, tick_b},
          {47'd0, m_out[1], m_rise[1], m_fall[1], m_lp[1], m_tick[1]});
    end
  end

  int lp_first, lp_cnt, n, cnt_o, cnt_r, cnt_f;
  bit seen;

  initial begin
    in_a = '0;
    in_b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_a", 64'(out_a), 64'h0);
    chk("reset_tick_b", 64'(tick_b), 64'h0);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("first_tick", 64'(tick_b), 64'(j == 4));
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!tick_b && n < 20);
    chk("tick_period", 64'(n), 64'd4);

    // Step on channel 0 of the RATE=1 instance; edge 0 is the edge just before.
    @(negedge clk);
    in_a[0] = 1'b1;
    lp_first = 0; lp_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 6) chk("lat_out_before", 64'(out_a[0]), 64'h0);
      if (k == 7) begin
        chk("lat_out_at7", 64'(out_a[0]), 64'h1);
        chk("lat_rise_at7", 64'(rise_a), 64'h1);
        chk("lat_fall_at7", 64'(fall_a), 64'h0);
      end
      if (k == 8) chk("lat_rise_after", 64'(rise_a[0]), 64'h0);
      if (lp_a[0]) begin
        lp_cnt++;
        if (lp_first == 0) lp_first = k;
      end
    end
`ifdef TAXI_DEBOUNCE_LONG_PRESS_EN
    chk("lp_first_edge", 64'(lp_first), 64'd15);
    chk("lp_no_repeat", 64'(lp_cnt), 64'd1);
`else
    chk("lp_tied_zero", 64'(lp_cnt), 64'd0);
`endif

    // Release, re-press, measure rise-to-long-press distance.
    in_a[0] = 1'b0;
    repeat (15) @(negedge clk);
    in_a[0] = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      if (rise_a[0]) seen = 1'b1;
    end
    chk("repress_rise_seen", 64'(seen), 64'h1);
    seen = 1'b0; n = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (lp_a[0] && !seen) begin seen = 1'b1; n = j; end
    end
`ifdef TAXI_DEBOUNCE_LONG_PRESS_EN
    chk("repress_lp_delay", 64'(n), 64'd8);
`else
    chk("repress_lp_zero", 64'(seen), 64'h0);
`endif

    // All four channels step together.
    in_a = '0;
    repeat (15) @(negedge clk);
    in_a = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (rise_a == '0 && n < 20);
    chk("simul_rise", 64'(rise_a), 64'hF);
    @(negedge clk);
    chk("simul_rise_clear", 64'(rise_a), 64'h0);

    // Short pulse of 3 ticks on channel 1 of the RATE=4 instance.
    in_b[1] = 1'b1;
    repeat (12) @(negedge clk);
    in_b[1] = 1'b0;
    cnt_o = 0; cnt_r = 0; cnt_f = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (out_b[1]) cnt_o++;
      if (rise_b[1]) cnt_r++;
      if (fall_b[1]) cnt_f++;
    end
    chk("glitch_out", 64'(cnt_o), 64'd0);
    chk("glitch_edges", 64'(cnt_r + cnt_f), 64'd0);

    // Bounce channel 2 once per tick for 10 ticks, then hold high.
    for (int j = 0; j < 10; j++) begin
      in_b[2] = ~in_b[2];
      repeat (4) @(negedge clk);
    end
    in_b[2] = 1'b1;
    cnt_r = 0; cnt_f = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (rise_b[2]) cnt_r++;
      if (fall_b[2]) cnt_f++;
    end
    chk("bounce_one_rise", 64'(cnt_r), 64'd1);
    chk("bounce_no_fall", 64'(cnt_f), 64'd0);

    // Asynchronous reset in the middle of a cycle with all outputs high.
    in_a = 4'hF;
    in_b = 4'hF;
    repeat (30) @(negedge clk);
    chk("pre_reset_out_b", 64'(out_b), 64'hF);
    chk("pre_reset_out_a", 64'(out_a), 64'hF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_a", 64'(out_a), 64'h0);
    chk("async_out_b", 64'(out_b), 64'h0);
    chk("async_no_fall", 64'({fall_a, fall_b}), 64'h0);
    repeat (2) @(negedge clk);
    chk("reset_hold_fall", 64'({fall_a, fall_b}), 64'h0);
    rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("rel_first_tick", 64'(tick_b), 64'(j == 4));
      chk("rel_no_fall", 64'({fall_a, fall_b}), 64'h0);
    end
    in_a = '0;
    in_b = '0;
    repeat (40) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
